// File: rtl/laplace_window_gen_pkg.sv
// Shared types and sizing helpers for the laplace4 streaming window generator.
// Counter widths come from cnt_w so that degenerate sizes still get at least one bit.
package laplace_pkg;

    localparam int DEF_ROWS   = 512;
    localparam int DEF_COLS   = 512;
    localparam int DEF_DATA_W = 8;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ROW_W = cnt_w(DEF_ROWS);
    localparam int DEF_COL_W = cnt_w(DEF_COLS);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/laplace_window_gen_line_buffer.sv
// DEPTH-deep shift buffer with enable; dout is the sample written DEPTH shifts ago.
// Contents are deliberately not reset: the window generator masks stale data by position.
module line_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [DATA_W-1:0] q;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (en) begin
                        q <= din;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (en) begin
                        q <= g_stage[gi-1].q;
                    end
                end
            end
        end
    endgenerate

    assign dout = g_stage[DEPTH-1].q;

endmodule

// File: rtl/laplace_window_gen.sv
// Turns a raster pixel stream into zero-padded 4-neighbour cross windows, one per pixel,
// using a 2*COLS+1 delay line (two line buffers plus tap registers) and a registered output.
module laplace_window_gen
    import laplace_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_pixel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_d,
    output logic [DATA_W-1:0] out_e,
    output logic [DATA_W-1:0] out_f,
    output logic [DATA_W-1:0] out_h,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int RW = cnt_w(ROWS);
    localparam int CW = cnt_w(COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    state_t            state_reg;
    logic [RW-1:0]     in_row_reg, cr_reg;
    logic [CW-1:0]     in_col_reg, cc_reg;
    logic [DATA_W-1:0] h_reg, e_reg, d_reg;
    logic [DATA_W-1:0] f_tap, b_tap, shift_pixel;
    logic              slot_free, accept, advance, emit, in_last, centre_last;

    assign slot_free   = !out_valid || out_ready;
    assign in_ready    = slot_free && (state_reg != FLUSH);
    assign accept      = in_valid && in_ready;
    assign advance     = (state_reg == FLUSH) ? slot_free : accept;
    assign emit        = advance && (state_reg != FILL);
    assign shift_pixel = (state_reg == FLUSH) ? '0 : in_pixel;
    assign in_last     = (in_row_reg == ROW_LAST) && (in_col_reg == COL_LAST);
    assign centre_last = (cr_reg == ROW_LAST) && (cc_reg == COL_LAST);

    // Window is taken from the delay line before the shift: h is the newest stored pixel.
    line_buffer #(.DEPTH(COLS), .DATA_W(DATA_W)) u_lb_near (
        .clk  (clk),
        .en   (advance),
        .din  (shift_pixel),
        .dout (f_tap)
    );

    line_buffer #(.DEPTH(COLS), .DATA_W(DATA_W)) u_lb_far (
        .clk  (clk),
        .en   (advance),
        .din  (e_reg),
        .dout (b_tap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_reg <= '0;
            e_reg <= '0;
            d_reg <= '0;
        end else if (advance) begin
            h_reg <= shift_pixel;
            e_reg <= f_tap;
            d_reg <= e_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= FILL;
            in_row_reg <= '0;
            in_col_reg <= '0;
            cr_reg     <= '0;
            cc_reg     <= '0;
            out_b      <= '0;
            out_d      <= '0;
            out_e      <= '0;
            out_f      <= '0;
            out_h      <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            if (accept) begin
                if (in_col_reg == COL_LAST) begin
                    in_col_reg <= '0;
                    in_row_reg <= in_last ? '0 : in_row_reg + 1'b1;
                end else begin
                    in_col_reg <= in_col_reg + 1'b1;
                end
            end

            if (emit) begin
                if (cc_reg == COL_LAST) begin
                    cc_reg <= '0;
                    cr_reg <= centre_last ? '0 : cr_reg + 1'b1;
                end else begin
                    cc_reg <= cc_reg + 1'b1;
                end
                // Border masking uses centre position only; buffer contents may be stale.
                out_b     <= (cr_reg == '0)       ? '0 : b_tap;
                out_h     <= (cr_reg == ROW_LAST) ? '0 : h_reg;
                out_d     <= (cc_reg == '0)       ? '0 : d_reg;
                out_f     <= (cc_reg == COL_LAST) ? '0 : f_tap;
                out_e     <= e_reg;
                out_valid <= 1'b1;
                out_last  <= centre_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            case (state_reg)
                FILL:    if (accept && (in_row_reg == ROW_ONE) && (in_col_reg == '0)) state_reg <= RUN;
                RUN:     if (accept && in_last) state_reg <= FLUSH;
                FLUSH:   if (emit && centre_last) state_reg <= FILL;
                default: state_reg <= FILL;
            endcase
        end
    end

endmodule

// File: doc/laplace_window_gen.md
# laplace_window_gen

- Streaming front end for the `laplace4` 4-neighbour filter.
- Consumes a raster-order pixel stream one pixel per handshake and emits, for every image pixel, the cross window `b`/`d`/`e`/`f`/`h` centred on it. Neighbours outside the image are zero-padded.
- Replaces file-driven window assembly so `laplace4` can be fed from a live pixel stream.

## Interface
- `ROWS`, 512, image height in pixels
- `COLS`, 512, image width in pixels (≥ 3)
- `DATA_W`, 8, pixel width
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_pixel`  in  DATA_W  raster-order input pixel
- `in_valid`  in  1  `in_pixel` valid
- `in_ready`  out  1  block accepts `in_pixel` this cycle
- `out_b`, `out_d`, `out_e`, `out_f`, `out_h`  out  DATA_W each  up, left, centre, right, down neighbours
- `out_valid`  out  1  window valid
- `out_ready`  in  1  downstream accepts window
- `out_last`  out  1  window centre is pixel (ROWS-1, COLS-1)

## Operation
- Pixel index n = row·COLS + col.
- Delay line of depth 2·COLS+1, built from two line buffers plus tap registers.
- When input index n enters the delay line, the centre is c = n − COLS − 1, and the taps are:
  - `h` = n−1
  - `f` = n−COLS
  - `e` = c
  - `d` = n−COLS−2
  - `b` = n−2·COLS−1
- Border masking is driven by the centre row/col counters (cr, cc). Buffer contents are never trusted:
  - `b` = 0 when cr = 0
  - `h` = 0 when cr = ROWS−1
  - `d` = 0 when cc = 0
  - `f` = 0 when cc = COLS−1
- Advance condition: a shift occurs when (FILL/RUN and `in_valid && in_ready`) or (FLUSH and output slot free). Output slot free = `!out_valid || out_ready`.
- `in_ready` = slot free and state ≠ FLUSH.
- States:
  - FILL: accept the first COLS+1 pixels of a frame; no windows emitted; go to RUN after pixel index COLS is accepted.
  - RUN: every accepted pixel produces one window; after pixel ROWS·COLS−1 is accepted, go to FLUSH.
  - FLUSH: shift in zero COLS+1 times, one window per shift; after the window with `out_last` is produced, go to FILL for the next frame.
- Exactly ROWS·COLS windows per frame, in raster order of centre.
- `out_last` is asserted only on the final window of a frame.
- Counters:
  - input row/col wrap col COLS−1 → 0 and increment row.
  - centre cr/cc wrap the same way and advance only when a window is emitted.
  - All counters clear at frame end.

## Timing
- Reset values: `out_*` data 0, `out_valid` 0, `out_last` 0, `in_ready` 1, state FILL, all counters 0. Line-buffer contents are not reset.
- Output register: the window for centre c is presented the cycle after input pixel c+COLS+1 is accepted (1-cycle registered latency), or the cycle after the corresponding FLUSH shift.
- Backpressure: while `out_valid && !out_ready`, outputs hold stable and the delay line, counters and state are frozen; `in_ready` = 0.
- Throughput: one window per cycle when `in_valid` and `out_ready` are held high.
- Gaps: deasserting `in_valid` in FILL/RUN inserts bubbles only; no state is lost.
- Mid-frame reset: immediate return to reset values; the next accepted pixel is treated as (0,0).
- `out_valid` and `out_last` deassert together when the last window is accepted.

## Structure
- Package `laplace_pkg`:
  - state enum {FILL, RUN, FLUSH}
  - default `ROWS`/`COLS`/`DATA_W` constants
  - `$clog2`-based counter width localparams
- Sub-module `line_buffer`: parameterised COLS-deep, DATA_W-wide shift buffer with enable (register array or inferred RAM plus pointer). Instantiated twice.
- Top: FSM, counters, tap registers, border mux, output register. Target ≈ 250 lines.

## Test plan
Unless stated otherwise, ROWS = COLS = 4, `in_pixel` = n+1 (values 1..16), `in_valid` = 1, `out_ready` = 1.
- Corner: first window → b0 d0 e1 f2 h5; last window → b12 d15 e16 f0 h0, `out_last` = 1; exactly 16 windows.
- Interior: centre (1,1) → b2 d5 e6 f7 h10; first window appears the cycle after the 6th pixel is accepted.
- Row wrap masking: centre (1,0) → d0 (not 4), b1 e5 f6 h9. Centre (0,3) → f0 (not 5), b0 d3 e4 h8.
- Backpressure: hold `out_ready` low 5 cycles at centre (2,2) → outputs frozen at b7 d10 e11 f12 h15 and `in_ready` = 0; the sequence resumes with no loss or duplication. Also run random `in_valid` gaps over the full frame.
- Frame boundary: two back-to-back frames (second frame values 101..116) → `in_ready` low exactly 5 FLUSH cycles; second frame's first window is b0 d0 e101 f102 h105.
- Reset: assert `rst_n` low after pixel 9 → `out_valid` 0 immediately. Restarted frame output matches the corner case exactly, with stale buffer data masked.
